ysyx_23060025_icache: RTL and testbench

Direct-mapped, read-only instruction cache. It is the responder on the fetch-stage request interface (psel/paddr in, pready/prdata out) and sits between the IFU stage and the memory bus. Misses refill one full line with an AXI4 INCR burst read, and the requested word is returned after the refill. A fence.i pulse invalidates the whole cache.

---
 rtl/ysyx_23060025_icache_if.sv | 50 +++++
 rtl/ysyx_23060025_icache.sv | 202 ++++++++++++++++++++
 tb/tb_ysyx_23060025_icache.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060025_icache_if.sv
//------------------------------------------------------------------------------
// Module   : ysyx_23060025_icache_if
// Brief    : Fetch-request and AXI4 read bus bundle for the instruction cache.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ysyx_23060025_icache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  in_psel;
    logic [ADDR_WIDTH-1:0] in_paddr;
    logic                  in_pready;
    logic [DATA_WIDTH-1:0] in_prdata;

    logic                  mem_arvalid;
    logic                  mem_arready;
    logic [ADDR_WIDTH-1:0] mem_araddr;
    logic [7:0]            mem_arlen;
    logic [2:0]            mem_arsize;
    logic [1:0]            mem_arburst;
    logic                  mem_rvalid;
    logic                  mem_rready;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [1:0]            mem_rresp;
    logic                  mem_rlast;

    // The cache: responder on the fetch side, requester on the memory side.
    modport slave (
        input  in_psel, in_paddr,
        output in_pready, in_prdata,
        output mem_arvalid, mem_araddr, mem_arlen, mem_arsize, mem_arburst,
        input  mem_arready,
        input  mem_rvalid, mem_rdata, mem_rresp, mem_rlast,
        output mem_rready
    );

    // The surroundings: fetch stage plus memory.
    modport master (
        output in_psel, in_paddr,
        input  in_pready, in_prdata,
        input  mem_arvalid, mem_araddr, mem_arlen, mem_arsize, mem_arburst,
        output mem_arready,
        output mem_rvalid, mem_rdata, mem_rresp, mem_rlast,
        input  mem_rready
    );
endinterface

`default_nettype wire

// File: rtl/ysyx_23060025_icache.sv
//------------------------------------------------------------------------------
// Module   : ysyx_23060025_icache
// Brief    : Direct-mapped read-only I-cache, AXI4 INCR line refill, fence.i.
//            ICACHE_PERF_COUNTER_EN adds perf_hit_cnt / perf_miss_cnt outputs.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ysyx_23060025_icache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16
) (
    input  wire                   clock,
    input  wire                   reset,
    input  wire                   fence_i_i,
    ysyx_23060025_icache_if.slave bus
`ifdef ICACHE_PERF_COUNTER_EN
    ,
    output logic [31:0]           perf_hit_cnt,
    output logic [31:0]           perf_miss_cnt
`endif
);
    localparam int OFF_W  = $clog2(LINE_WORDS * 4);
    localparam int WSEL_W = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;
    localparam int LINE_W = ADDR_WIDTH - OFF_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_AR     = 3'd2;
    localparam logic [2:0] S_REFILL = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [SETS-1:0]       valid_q;
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [DATA_WIDTH-1:0] data_q [SETS][LINE_WORDS];
    logic [WSEL_W-1:0]     cnt_q;
    logic [WSEL_W-1:0]     wsel_q;
    logic [LINE_W-1:0]     line_q;
    logic                  pending_q;
    logic                  err_q;
    logic                  fence_seen_q;
    logic [DATA_WIDTH-1:0] bypass_q;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WSEL_W-1:0] req_wsel;
    logic [IDX_W-1:0]  line_idx;
    logic [TAG_W-1:0]  line_tag;
    logic              hit;
    logic              lookup;
    logic              beat;
    logic              last;
    logic              beat_err;
    logic              unused_paddr_lsb;

    assign req_tag  = bus.in_paddr[ADDR_WIDTH-1 -: TAG_W];
    assign req_idx  = bus.in_paddr[OFF_W +: IDX_W];
    assign req_wsel = bus.in_paddr[2 +: WSEL_W];
    assign line_idx = line_q[IDX_W-1:0];
    assign line_tag = line_q[LINE_W-1 -: TAG_W];
    assign unused_paddr_lsb = ^bus.in_paddr[1:0];

    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign lookup   = (state_q == S_LOOKUP);
    assign beat     = (state_q == S_REFILL) && bus.mem_rvalid;
    assign last     = beat && bus.mem_rlast;
    assign beat_err = (bus.mem_rresp != 2'b00);

    assign bus.mem_araddr  = {line_q, {OFF_W{1'b0}}};
    assign bus.mem_arlen   = 8'(LINE_WORDS - 1);
    assign bus.mem_arsize  = 3'b010;
    assign bus.mem_arburst = 2'b01;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.in_psel) state_d = S_LOOKUP;
            S_LOOKUP: begin
                if (hit) begin
                    state_d = bus.in_psel ? S_LOOKUP : S_IDLE;
                end else begin
                    state_d = S_AR;
                end
            end
            S_AR:     if (bus.mem_arready) state_d = S_REFILL;
            // A newer fetch arrived during the burst: drop the stale reply.
            S_REFILL: begin
                if (last) begin
                    state_d = (pending_q || bus.in_psel) ? S_LOOKUP : S_RESP;
                end
            end
            S_RESP:   state_d = bus.in_psel ? S_LOOKUP : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_pready   = 1'b0;
        bus.in_prdata   = '0;
        bus.mem_arvalid = 1'b0;
        bus.mem_rready  = 1'b0;
        case (state_q)
            S_LOOKUP: begin
                bus.in_pready = hit;
                if (hit) bus.in_prdata = data_q[req_idx][req_wsel];
            end
            S_AR:     bus.mem_arvalid = 1'b1;
            S_REFILL: bus.mem_rready  = 1'b1;
            S_RESP: begin
                bus.in_pready = 1'b1;
                bus.in_prdata = err_q ? bypass_q : data_q[line_idx][wsel_q];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q      <= '0;
            cnt_q        <= '0;
            wsel_q       <= '0;
            line_q       <= '0;
            pending_q    <= 1'b0;
            err_q        <= 1'b0;
            fence_seen_q <= 1'b0;
            bypass_q     <= '0;
        end else begin
            if (lookup && !hit) begin
                line_q       <= bus.in_paddr[ADDR_WIDTH-1:OFF_W];
                wsel_q       <= req_wsel;
                err_q        <= 1'b0;
                fence_seen_q <= 1'b0;
                pending_q    <= 1'b0;
            end
            if (((state_q == S_AR) || (state_q == S_REFILL)) && bus.in_psel) begin
                pending_q <= 1'b1;
            end
            if ((state_q == S_AR) && bus.mem_arready) begin
                cnt_q <= '0;
            end
            if (beat) begin
                cnt_q <= cnt_q + WSEL_W'(1);
                if (beat_err) err_q <= 1'b1;
                if (cnt_q == wsel_q) bypass_q <= bus.mem_rdata;
            end
            if (last) begin
                pending_q <= 1'b0;
            end
            if (fence_i_i && ((state_q == S_AR) || (state_q == S_REFILL))) begin
                fence_seen_q <= 1'b1;
            end
            // The set being overwritten is invalid for the whole burst.
            if (fence_i_i) begin
                valid_q <= '0;
            end else if ((state_q == S_AR) && bus.mem_arready) begin
                valid_q[line_idx] <= 1'b0;
            end else if (last) begin
                valid_q[line_idx] <= !err_q && !beat_err && !fence_seen_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (beat) begin
            data_q[line_idx][cnt_q] <= bus.mem_rdata;
        end
        if (last) begin
            tag_q[line_idx] <= line_tag;
        end
    end

`ifdef ICACHE_PERF_COUNTER_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_hit_cnt  <= '0;
            perf_miss_cnt <= '0;
        end else if (lookup) begin
            if (hit) begin
                perf_hit_cnt <= perf_hit_cnt + 32'd1;
            end else begin
                perf_miss_cnt <= perf_miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060025_icache.sv
//------------------------------------------------------------------------------
// Module   : tb_ysyx_23060025_icache
// Brief    : Directed bench for ysyx_23060025_icache with a response scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ysyx_23060025_icache;
    logic clock   = 1'b0;
    logic reset   = 1'b1;
    logic fence_i = 1'b0;

    always #5 clock = ~clock;

    ysyx_23060025_icache_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef ICACHE_PERF_COUNTER_EN
    logic [31:0] perf_hit_cnt;
    logic [31:0] perf_miss_cnt;
`endif

    ysyx_23060025_icache #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(4), .SETS(16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .fence_i_i (fence_i),
        .bus       (bus)
`ifdef ICACHE_PERF_COUNTER_EN
        ,
        .perf_hit_cnt  (perf_hit_cnt),
        .perf_miss_cnt (perf_miss_cnt)
`endif
    );

    int          checks   = 0;
    int          errors   = 0;
    int          ar_count = 0;
    int          err_beat = -1;
    int          ar0;
    bit          got;
    logic [31:0] mem_base;
    logic [31:0] sb_q[$];
    logic [31:0] ar_exp_q[$];

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Memory image: the first line holds the known instruction words.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (a[31:4] == 28'h8000_000) begin
            case (a[3:2])
                2'd0:    w = 32'h11;
                2'd1:    w = 32'h22;
                2'd2:    w = 32'h33;
                default: w = 32'h44;
            endcase
        end else begin
            w = a ^ 32'h5A5A_5A5A;
        end
        return w;
    endfunction

    always @(negedge clock) begin : mon
        bit have;
        if (!reset && bus.in_pready === 1'b1) begin
            have = (sb_q.size() != 0);
            chk("pready_expected", {31'b0, have}, 32'd1);
            if (have) chk("prdata", bus.in_prdata, sb_q.pop_front());
        end
    end

    initial begin
        bus.mem_arready = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;
        bus.mem_rresp   = 2'b00;
        bus.mem_rlast   = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (!reset && bus.mem_arvalid === 1'b1) begin
                mem_base = bus.mem_araddr;
                if (ar_exp_q.size() == 0) chk("ar_expected", {31'b0, bus.mem_arvalid}, 32'd0);
                else chk("araddr", bus.mem_araddr, ar_exp_q.pop_front());
                chk("arlen", {24'b0, bus.mem_arlen}, 32'd3);
                chk("arsize", {29'b0, bus.mem_arsize}, 32'd2);
                chk("arburst", {30'b0, bus.mem_arburst}, 32'd1);
                bus.mem_arready = 1'b1;
                @(posedge clock); #1;
                bus.mem_arready = 1'b0;
                ar_count++;
                repeat (2) begin @(posedge clock); #1; end
                for (int i = 0; i < 4; i++) begin
                    chk("rready", {31'b0, bus.mem_rready}, 32'd1);
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = mem_word(mem_base + 32'(4 * i));
                    bus.mem_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
                    bus.mem_rlast  = (i == 3);
                    @(posedge clock); #1;
                end
                bus.mem_rvalid = 1'b0;
                bus.mem_rlast  = 1'b0;
                bus.mem_rresp  = 2'b00;
            end
        end
    end

    task automatic wait_pready(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < 60) begin
            @(negedge clock);
            if (bus.in_pready === 1'b1) ok = 1'b1;
            n++;
        end
    endtask

    task automatic wait_rready(input string name);
        int n = 0;
        @(negedge clock);
        while (bus.mem_rready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk({name, "_rready"}, {31'b0, bus.mem_rready}, 32'd1);
    endtask

    // fc: 0 no fence, 1 fence together with psel, 2 fence in the lookup cycle
    task automatic fetch(input logic [31:0] a, input bit exp_miss, input int fc, input string name);
        int start;
        int lat;
        bit ok;
        start = ar_count;
        sb_q.push_back(mem_word(a));
        if (exp_miss) ar_exp_q.push_back({a[31:4], 4'h0});
        @(posedge clock); #1;
        bus.in_psel  = 1'b1;
        bus.in_paddr = a;
        fence_i      = (fc == 1);
        @(posedge clock); #1;
        bus.in_psel  = 1'b0;
        fence_i      = (fc == 2);
        lat = 1;
        ok  = 1'b0;
        while (!ok && lat < 60) begin
            @(negedge clock);
            if (bus.in_pready === 1'b1) ok = 1'b1;
            else begin
                @(posedge clock); #1;
                fence_i = 1'b0;
                lat++;
            end
        end
        if (fence_i) begin
            @(posedge clock); #1;
            fence_i = 1'b0;
        end
        chk({name, "_pready"}, {31'b0, ok}, 32'd1);
        chk({name, "_ar"}, 32'(ar_count - start), exp_miss ? 32'd1 : 32'd0);
        if (!exp_miss) chk({name, "_lat"}, 32'(lat), 32'd1);
    endtask

    initial begin
        bus.in_psel  = 1'b0;
        bus.in_paddr = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_pready", {31'b0, bus.in_pready}, 32'd0);
        chk("rst_prdata", bus.in_prdata, 32'd0);
        chk("rst_arvalid", {31'b0, bus.mem_arvalid}, 32'd0);
        chk("rst_rready", {31'b0, bus.mem_rready}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        fetch(32'h8000_0004, 1'b1, 0, "cold_miss");
        fetch(32'h8000_000C, 1'b0, 0, "hit");

        ar0 = ar_count;
        sb_q.push_back(32'h11);
        sb_q.push_back(32'h33);
        @(posedge clock); #1;
        bus.in_psel  = 1'b1;
        bus.in_paddr = 32'h8000_0000;
        @(posedge clock); #1;
        @(negedge clock);
        chk("b2b_first_pready", {31'b0, bus.in_pready}, 32'd1);
        @(posedge clock); #1;
        bus.in_psel  = 1'b0;
        bus.in_paddr = 32'h8000_0008;
        @(negedge clock);
        chk("b2b_second_pready", {31'b0, bus.in_pready}, 32'd1);
        chk("b2b_no_ar", 32'(ar_count - ar0), 32'd0);

        fetch(32'h8000_0100, 1'b1, 0, "conflict");
        fetch(32'h8000_0004, 1'b1, 0, "conflict_back");

        // 0x200 shares set 0, so the redirected fetch of 0x008 misses again.
        ar0 = ar_count;
        sb_q.push_back(32'h33);
        ar_exp_q.push_back(32'h8000_0200);
        ar_exp_q.push_back(32'h8000_0000);
        @(posedge clock); #1;
        bus.in_psel  = 1'b1;
        bus.in_paddr = 32'h8000_0200;
        @(posedge clock); #1;
        bus.in_psel  = 1'b0;
        wait_rready("cancel");
        @(posedge clock); #1;
        bus.in_psel  = 1'b1;
        bus.in_paddr = 32'h8000_0008;
        @(posedge clock); #1;
        bus.in_psel  = 1'b0;
        wait_pready(got);
        chk("cancel_pready", {31'b0, got}, 32'd1);
        chk("cancel_ar", 32'(ar_count - ar0), 32'd2);

        err_beat = 1;
        fetch(32'h8000_0358, 1'b1, 0, "err_fill");
        err_beat = -1;
        fetch(32'h8000_0358, 1'b1, 0, "err_refetch");
        fetch(32'h8000_035C, 1'b0, 0, "err_then_hit");

        fetch(32'h8000_0000, 1'b0, 0, "pre_fence_hit");
        @(posedge clock); #1;
        fence_i = 1'b1;
        @(posedge clock); #1;
        fence_i = 1'b0;
        fetch(32'h8000_0000, 1'b1, 0, "post_fence");

        ar0 = ar_count;
        sb_q.push_back(mem_word(32'h8000_0100));
        ar_exp_q.push_back(32'h8000_0100);
        @(posedge clock); #1;
        bus.in_psel  = 1'b1;
        bus.in_paddr = 32'h8000_0100;
        @(posedge clock); #1;
        bus.in_psel  = 1'b0;
        wait_rready("fence_refill");
        @(posedge clock); #1;
        fence_i = 1'b1;
        @(posedge clock); #1;
        fence_i = 1'b0;
        wait_pready(got);
        chk("fence_refill_pready", {31'b0, got}, 32'd1);
        chk("fence_refill_ar", 32'(ar_count - ar0), 32'd1);
        fetch(32'h8000_0100, 1'b1, 0, "fence_refill_remiss");

        fetch(32'h8000_0104, 1'b0, 2, "fence_in_lookup_hit");
        fetch(32'h8000_0100, 1'b1, 0, "after_lookup_fence");
        fetch(32'h8000_0100, 1'b1, 1, "fence_with_psel");

        repeat (4) @(posedge clock);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("ar_drained", 32'(ar_exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, required finish before 200000");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
